// File: rtl/spi_slave_if_pkg.sv
// Shared SPI definitions: FSM state encoding and {CPOL,CPHA} mode constants,
// common to this responder and the AHB-side SPI master.
package spi_slave_if_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_slave_if_in_sync.sv
// Brings one asynchronous SPI pin into the HCLK domain through a flop chain
// and reports its settled level plus single-cycle rise/fall strobes.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge HCLK or negedge HRESETn) begin
          if (!HRESETn) sync_reg[gi] <= RST_VAL;
          else          sync_reg[gi] <= din;
        end
      end else begin : g_next
        always_ff @(posedge HCLK or negedge HRESETn) begin
          if (!HRESETn) sync_reg[gi] <= RST_VAL;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hist_reg <= RST_VAL;
    else          hist_reg <= sync_reg[STAGES-1];
  end

  assign level = sync_reg[STAGES-1];
  assign rise  =  level & ~hist_reg;
  assign fall  = ~level &  hist_reg;

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder: oversampled SCLK/SS/MOSI, MSB-first shifting in all four
// CPOL/CPHA modes, with valid/ready byte streams toward local logic.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_WORD   = 8'hFF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              SPI_CLK_i,
  input  logic              SPI_SS_i,
  input  logic              SPI_MOSI_i,
  output logic              SPI_MISO_o,
  output logic              SPI_MISO_OE_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(SPI_CLK_i),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // SS idles high, so its chain resets high to avoid a false select after reset.
  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(SPI_SS_i),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(SPI_MOSI_i),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

  spi_state_t        state_reg, state_next;
  logic [1:0]        mode_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              need_load_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              overrun_reg, underrun_reg, abort_reg;

  logic cpol, cpha, lead_edge, trail_edge, sample_edge, drive_edge;
  logic load, do_sample, do_shift, word_done, abort, tx_write;

  assign cpol        = mode_reg[1];
  assign cpha        = mode_reg[0];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge  : trail_edge;
  assign tx_write    = tx_valid_i && !hold_full_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    word_done  = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next = ST_SHIFT;
          load       = 1'b1;
        end
      end
      ST_SHIFT: begin
        do_sample = sample_edge;
        word_done = sample_edge && (bit_cnt_reg == CNT_W'(DATA_W - 1));
        // With CPHA=1 the first leading edge of a frame only presents the MSB.
        if (drive_edge) begin
          if (need_load_reg)                     load     = 1'b1;
          else if (!(cpha && bit_cnt_reg == '0)) do_shift = 1'b1;
        end
        if (ss_rise) begin
          state_next = ST_IDLE;
          abort      = (bit_cnt_reg != '0) && !word_done;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_reg      <= '0;
      bit_cnt_reg   <= '0;
      need_load_reg <= 1'b0;
      tx_shift_reg  <= FILL_WORD;
      rx_shift_reg  <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE) mode_reg <= spi_mode(cpol_i, cpha_i);

      if (state_reg == ST_IDLE || ss_rise) bit_cnt_reg <= '0;
      else if (word_done)                  bit_cnt_reg <= '0;
      else if (do_sample)                  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);

      if (state_reg == ST_IDLE || ss_rise) need_load_reg <= 1'b0;
      else if (word_done)                  need_load_reg <= 1'b1;
      else if (load)                       need_load_reg <= 1'b0;

      // A same-cycle write lands in the holding reg after the load has read it.
      if (load)          tx_shift_reg <= hold_full_reg ? hold_reg : FILL_WORD;
      else if (do_shift) tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
      underrun_reg <= load && !hold_full_reg;

      if (tx_write)  hold_reg      <= tx_data_i;
      if (tx_write)  hold_full_reg <= 1'b1;
      else if (load) hold_full_reg <= 1'b0;

      if (do_sample) rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_level};

      if (word_done) begin
        rx_data_reg  <= {rx_shift_reg[DATA_W-2:0], mosi_level};
        rx_valid_reg <= 1'b1;
        overrun_reg  <= rx_valid_reg && !rx_ready_i;
      end else begin
        overrun_reg <= 1'b0;
        if (rx_valid_reg && rx_ready_i) rx_valid_reg <= 1'b0;
      end

      abort_reg <= abort;
    end
  end

  assign SPI_MISO_o    = tx_shift_reg[DATA_W-1];
  assign SPI_MISO_OE_o = (state_reg == ST_SHIFT);
  assign busy_o        = (state_reg == ST_SHIFT);
  assign tx_ready_o    = !hold_full_reg;
  assign rx_data_o     = rx_data_reg;
  assign rx_valid_o    = rx_valid_reg;
  assign rx_overrun_o  = overrun_reg;
  assign tx_underrun_o = underrun_reg;
  assign frame_abort_o = abort_reg;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: acts as an SPI master at HCLK:SCLK = 8:1
// and checks data, handshakes and status pulses against hand-computed values.
module tb_spi_slave_if;
  import spi_slave_if_pkg::*;

  logic       HCLK, HRESETn;
  logic       cpol, cpha, sclk, ss, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, tx_underrun, frame_abort, busy;

  spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2), .FILL_WORD(8'hFF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cpol_i(cpol), .cpha_i(cpha),
    .SPI_CLK_i(sclk), .SPI_SS_i(ss), .SPI_MOSI_i(mosi),
    .SPI_MISO_o(miso), .SPI_MISO_OE_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun),
    .frame_abort_o(frame_abort), .busy_o(busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int und_cnt = 0, ovr_cnt = 0, abt_cnt = 0, edge_err = 0;
  logic [7:0] rxq[$];

  // Pulse and accept monitor, sampled 1 ns after each rising edge.
  always begin
    @(posedge HCLK);
    #1;
    if (tx_underrun === 1'b1) und_cnt++;
    if (rx_overrun === 1'b1)  ovr_cnt++;
    if (frame_abort === 1'b1) abt_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) rxq.push_back(rx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge HCLK);
    cpol = m[1];
    cpha = m[0];
    sclk = m[1];
    cyc(8);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    @(negedge HCLK);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge HCLK);
    tx_valid = 1'b0;
  endtask

  task automatic ss_fall();
    @(negedge HCLK);
    ss = 1'b0;
    cyc(8);
  endtask

  task automatic ss_rise();
    cyc(4);
    ss = 1'b1;
    cyc(8);
  endtask

  task automatic accept();
    @(negedge HCLK);
    rx_ready = 1'b1;
    @(negedge HCLK);
    rx_ready = 1'b0;
  endtask

  // Master side of one word (or nbits of it); also flags MISO moving on the wrong edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        cyc(4);
        sclk = ~cpol;
        r = {r[6:0], miso};
        cyc(4);
        if (miso !== r[0]) edge_err++;
        sclk = cpol;
      end else begin
        if (i > 0 && miso !== r[0]) edge_err++;
        sclk = ~cpol;
        mosi = mo[7-i];
        cyc(4);
        sclk = cpol;
        r = {r[6:0], miso};
        cyc(4);
      end
    end
    mi = r;
  endtask

  logic [7:0] m0, m1, m2;
  int u0, o0, a0;

  initial begin
    HRESETn = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    cyc(3);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_miso", miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {tx_underrun, rx_overrun, frame_abort}, 0);
    HRESETn = 1'b1;
    cyc(4);

    // Single word A5 out / 3C in, in each of the four modes.
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1:0]);
      chk($sformatf("m%0d_tx_ready_idle", m), tx_ready, 1);
      queue_tx(8'hA5);
      chk($sformatf("m%0d_tx_ready_held", m), tx_ready, 0);
      u0 = und_cnt; o0 = ovr_cnt; a0 = abt_cnt; edge_err = 0;
      ss_fall();
      chk($sformatf("m%0d_busy", m), busy, 1);
      chk($sformatf("m%0d_oe_on", m), miso_oe, 1);
      chk($sformatf("m%0d_tx_ready_loaded", m), tx_ready, 1);
      xfer(8'h3C, 8, m0);
      ss_rise();
      chk($sformatf("m%0d_miso_byte", m), m0, 8'hA5);
      chk($sformatf("m%0d_rx_data", m), rx_data, 8'h3C);
      chk($sformatf("m%0d_rx_valid", m), rx_valid, 1);
      // CPHA=0 loads the next word on the final trailing edge, which finds the holding reg empty.
      chk($sformatf("m%0d_underrun", m), und_cnt - u0, (m[0] ? 0 : 1));
      chk($sformatf("m%0d_overrun", m), ovr_cnt - o0, 0);
      chk($sformatf("m%0d_abort", m), abt_cnt - a0, 0);
      chk($sformatf("m%0d_miso_edge", m), edge_err, 0);
      chk($sformatf("m%0d_oe_off", m), miso_oe, 0);
      accept();
      chk($sformatf("m%0d_rx_cleared", m), rx_valid, 0);
    end

    // Three back-to-back words in mode 1 with only 77 queued.
    set_mode(MODE1);
    rx_ready = 1'b1;
    rxq.delete();
    queue_tx(8'h77);
    u0 = und_cnt;
    ss_fall();
    xfer(8'h11, 8, m0);
    xfer(8'h22, 8, m1);
    xfer(8'h33, 8, m2);
    ss_rise();
    rx_ready = 1'b0;
    chk("b2b_miso0", m0, 8'h77);
    chk("b2b_miso1", m1, 8'hFF);
    chk("b2b_miso2", m2, 8'hFF);
    chk("b2b_underrun", und_cnt - u0, 2);
    chk("b2b_rx_count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("b2b_rx0", rxq[0], 8'h11);
      chk("b2b_rx1", rxq[1], 8'h22);
      chk("b2b_rx2", rxq[2], 8'h33);
    end
    chk("b2b_rx_valid", rx_valid, 0);

    // Overrun: consumer stalled across two words.
    set_mode(MODE0);
    o0 = ovr_cnt;
    ss_fall();
    xfer(8'h01, 8, m0);
    xfer(8'h02, 8, m1);
    ss_rise();
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_rx_data", rx_data, 8'h02);
    chk("ovr_rx_valid", rx_valid, 1);
    accept();

    // Abort after 5 bits, then a clean frame.
    a0 = abt_cnt;
    ss_fall();
    xfer(8'hF0, 5, m0);
    ss_rise();
    chk("abt_pulses", abt_cnt - a0, 1);
    chk("abt_rx_valid", rx_valid, 0);
    chk("abt_oe", miso_oe, 0);
    chk("abt_busy", busy, 0);
    ss_fall();
    xfer(8'h5A, 8, m0);
    ss_rise();
    chk("abt_next_rx_data", rx_data, 8'h5A);
    chk("abt_next_rx_valid", rx_valid, 1);
    chk("abt_next_no_pulse", abt_cnt - a0, 1);
    accept();

    // Reset in the middle of a word.
    queue_tx(8'h96);
    ss_fall();
    xfer(8'hAA, 3, m0);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_miso", miso, 1);
    chk("mid_rst_oe", miso_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_pulses", {tx_underrun, rx_overrun, frame_abort}, 0);
    ss = 1'b1;
    sclk = cpol;
    cyc(4);
    HRESETn = 1'b1;
    cyc(4);
    a0 = abt_cnt;
    ss_fall();
    xfer(8'hC3, 8, m0);
    ss_rise();
    chk("post_rst_rx_data", rx_data, 8'hC3);
    chk("post_rst_rx_valid", rx_valid, 1);
    chk("post_rst_miso_fill", m0, 8'hFF);
    chk("post_rst_no_abort", abt_cnt - a0, 0);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
